// File: rtl/ro_pkg.sv
// Shared definitions for the readout transfer scheduler: word width, default
// geometry and the scheduler FSM state encoding.
package ro_pkg;

    localparam int WORD_W            = 32;
    localparam int DEFAULT_DEPTH     = 512;
    localparam int DEFAULT_BURST_LEN = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/ro_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy output. A write to a
// full FIFO is accepted only when a read frees a slot on the same cycle.
module ro_sync_fifo
    import ro_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    parameter  int WIDTH = WORD_W,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [LVL_W-1:0] level_o,
    output logic             empty_o,
    output logic             drop_o
);

    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full, wr_fire, rd_fire;

    assign full    = (level_q == FULL_LVL);
    assign empty_o = (level_q == '0);
    assign rd_fire = rd_en_i && !empty_o;
    assign wr_fire = wr_en_i && (!full || rd_fire);
    assign drop_o  = wr_en_i && !wr_fire;

    assign rd_data_o = mem_q[rd_ptr_q];
    assign level_o   = level_q;

    // NOTE: the storage array has no reset; occupancy is governed entirely by
    // the pointers and level, so stale contents are never observable.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_comb begin
        level_d = level_q;
        unique case ({wr_fire, rd_fire})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/ro_transfer_scheduler.sv
// Buffers readout words and streams them to the DMA in full bursts, or as a
// shorter drain burst once the measurement run has ended.
module ro_transfer_scheduler
    import ro_pkg::*;
#(
    parameter  int DEPTH     = DEFAULT_DEPTH,
    parameter  int BURST_LEN = DEFAULT_BURST_LEN,
    localparam int LVL_W     = $clog2(DEPTH) + 1
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              data_en,
    input  logic [WORD_W-1:0] data_in,
    input  logic              meas_done,
    input  logic              transfer_en,
    output logic              transfer_active,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic [LVL_W-1:0]  level,
    output logic              overflow,
    input  logic              ovf_clear
);

    localparam int               CNT_W     = $clog2(BURST_LEN) + 1;
    localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic              rst_sync_q;
    state_e            state_q, state_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic              flush_q, flush_d;
    logic              overflow_q, overflow_d;
    logic              active_q, active_d;
    logic              flush_clear, handshake;

    logic [WORD_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_empty, fifo_drop;

    // Assertion is immediate; release takes effect one edge later so the
    // first state update lands on the second edge after RESET_N rises.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    ro_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (CLK),
        .rst_n     (rst_sync_q),
        .wr_en_i   (data_en),
        .wr_data_i (data_in),
        .rd_en_i   (handshake),
        .rd_data_o (fifo_head),
        .level_o   (fifo_level),
        .empty_o   (fifo_empty),
        .drop_o    (fifo_drop)
    );

    assign handshake = m_valid && m_ready;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        m_valid  = 1'b0;
        m_last   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (transfer_en) begin
                    if (fifo_level >= BURST_LVL) begin
                        state_d  = ST_BURST;
                        remain_d = BURST_CNT;
                    end else if (flush_q && fifo_level != '0) begin
                        state_d  = ST_DRAIN;
                        remain_d = CNT_W'(fifo_level);
                    end
                end
            end
            ST_BURST, ST_DRAIN: begin
                m_valid = !fifo_empty && (remain_q != '0);
                m_last  = m_valid && (remain_q == CNT_ONE);
                if (m_valid && m_ready) begin
                    remain_d = remain_q - 1'b1;
                    if (remain_q == CNT_ONE) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A pending flush is retired by a completed drain or an empty idle FIFO;
    // a meas_done pulse on that same cycle re-arms it.
    assign flush_clear = (state_q == ST_DRAIN && handshake && remain_q == CNT_ONE)
                      || (state_q == ST_IDLE && fifo_level == '0);
    assign flush_d     = meas_done || (flush_q && !flush_clear);
    assign overflow_d  = fifo_drop || (overflow_q && !ovf_clear);
    assign active_d    = (state_d != ST_IDLE);

    always_ff @(posedge CLK or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            state_q    <= ST_IDLE;
            remain_q   <= '0;
            flush_q    <= 1'b0;
            overflow_q <= 1'b0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            remain_q   <= remain_d;
            flush_q    <= flush_d;
            overflow_q <= overflow_d;
            active_q   <= active_d;
        end
    end

    assign m_data          = m_valid ? fifo_head : '0;
    assign level           = fifo_level;
    assign overflow        = overflow_q;
    assign transfer_active = active_q;

endmodule

// File: tb/tb_ro_transfer_scheduler.sv
// Directed self-checking bench for ro_transfer_scheduler with default
// geometry (512-word FIFO, 256-word bursts).
module tb_ro_transfer_scheduler;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        data_en;
    logic [31:0] data_in;
    logic        meas_done;
    logic        transfer_en;
    logic        transfer_active;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic [9:0]  level;
    logic        overflow;
    logic        ovf_clear;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] wr_val;
    logic [31:0] rd_exp;
    int          lvl_exp;
    int          burst_len_exp;
    int          burst_pos;
    int          cyc;

    always #5 CLK = ~CLK;

    ro_transfer_scheduler dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .data_en         (data_en),
        .data_in         (data_in),
        .meas_done       (meas_done),
        .transfer_en     (transfer_en),
        .transfer_active (transfer_active),
        .m_valid         (m_valid),
        .m_ready         (m_ready),
        .m_data          (m_data),
        .m_last          (m_last),
        .level           (level),
        .overflow        (overflow),
        .ovf_clear       (ovf_clear)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_n(input int n);
        data_en = 1'b1;
        repeat (n) begin
            data_in = wr_val;
            tick();
            wr_val++;
            lvl_exp++;
        end
        data_en = 1'b0;
        check("level after writes", level, lvl_exp);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " transfer_active"}, transfer_active, 0);
        check({tag, " m_valid"}, m_valid, 0);
        check({tag, " m_last"}, m_last, 0);
        check({tag, " m_data"}, m_data, 0);
        check({tag, " level"}, level, 0);
        check({tag, " overflow"}, overflow, 0);
    endtask

    // Streams until n_hs handshakes and n_wr concurrent writes are done.
    task automatic run(input string tag, input int n_wr, input int n_hs,
                       input bit toggle, input int max_cyc, output int cyc_o);
        int          wr_done = 0;
        int          hs_done = 0;
        int          c = 0;
        int          idle_gap = 0;
        bit          stalled = 0;
        bit          after_last = 0;
        bit          hs;
        logic [31:0] hold_d = '0;
        logic        hold_l = 1'b0;
        while ((hs_done < n_hs || wr_done < n_wr) && c < max_cyc) begin
            data_en = (wr_done < n_wr);
            data_in = wr_val;
            m_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (stalled) begin
                check({tag, " stall m_valid"}, m_valid, 1);
                check({tag, " stall m_data"}, m_data, hold_d);
                check({tag, " stall m_last"}, m_last, hold_l);
            end
            if (after_last && !transfer_active) idle_gap++;
            hs      = m_valid && m_ready;
            stalled = m_valid && !m_ready;
            hold_d  = m_data;
            hold_l  = m_last;
            if (hs) begin
                if (after_last) begin
                    check({tag, " idle gap"}, idle_gap >= 1, 1);
                    after_last = 0;
                end
                check({tag, " m_data"}, m_data, rd_exp);
                check({tag, " m_last"}, m_last, burst_pos == burst_len_exp - 1);
                rd_exp++;
                hs_done++;
                if (burst_pos == burst_len_exp - 1) begin
                    burst_pos  = 0;
                    after_last = 1;
                    idle_gap   = 0;
                end else begin
                    burst_pos++;
                end
            end
            tick();
            if (data_en) begin
                wr_val++;
                wr_done++;
                lvl_exp++;
            end
            if (hs) lvl_exp--;
            check({tag, " level"}, level, lvl_exp);
            c++;
        end
        data_en = 1'b0;
        check({tag, " handshakes"}, hs_done, n_hs);
        cyc_o = c;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET_N       = 1'b0;
        data_en       = 1'b1;
        meas_done     = 1'b0;
        transfer_en   = 1'b0;
        m_ready       = 1'b0;
        ovf_clear     = 1'b0;
        wr_val        = 32'h1000_0000;
        rd_exp        = wr_val;
        data_in       = wr_val;
        lvl_exp       = 0;
        burst_len_exp = 256;
        burst_pos     = 0;

        // Reset state, then release timing with a write held pending.
        repeat (3) tick();
        check_idle_outputs("reset");
        RESET_N = 1'b1;
        tick();
        check("release edge1 level", level, 0);
        tick();
        check("release edge2 level", level, 1);
        data_en = 1'b0;
        wr_val++;
        lvl_exp = 1;

        // Full burst, back-to-back, transfer_en dropped mid-burst.
        write_n(255);
        m_ready = 1'b1;
        check("pre-burst transfer_active", transfer_active, 0);
        transfer_en = 1'b1;
        tick();
        check("burst latency transfer_active", transfer_active, 1);
        transfer_en = 1'b0;
        run("full burst", 0, 256, 0, 400, cyc);
        check("full burst cycles", cyc, 256);
        check("full burst end active", transfer_active, 0);
        check("full burst end m_valid", m_valid, 0);

        // Drain burst after meas_done.
        write_n(100);
        meas_done = 1'b1;
        tick();
        meas_done   = 1'b0;
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        check("drain start active", transfer_active, 1);
        burst_len_exp = 100;
        run("drain100", 0, 100, 0, 200, cyc);
        check("drain100 cycles", cyc, 100);
        check("drain100 end active", transfer_active, 0);

        // Flush is retired: a short FIFO alone does not start a drain.
        write_n(10);
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        check("no drain without flush", transfer_active, 0);
        tick();
        check("no drain m_valid", m_valid, 0);
        meas_done = 1'b1;
        tick();
        meas_done   = 1'b0;
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        burst_len_exp = 10;
        run("drain10", 0, 10, 0, 50, cyc);

        // Overflow: fill, drop, clear versus drop, clear.
        m_ready = 1'b0;
        write_n(512);
        check("full no overflow", overflow, 0);
        data_en = 1'b1;
        data_in = 32'hDEAD_BEEF;
        tick();
        check("drop sets overflow", overflow, 1);
        check("drop level", level, 512);
        ovf_clear = 1'b1;
        tick();
        check("clear with drop", overflow, 1);
        data_en = 1'b0;
        tick();
        check("clear overflow", overflow, 0);
        ovf_clear = 1'b0;

        // Burst from full with a write on the first handshake cycle.
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        check("burst from full active", transfer_active, 1);
        burst_len_exp = 256;
        run("full+write", 1, 256, 0, 400, cyc);

        // Ready toggling with concurrent writes.
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        run("toggle", 100, 256, 1, 1000, cyc);
        check("toggle end level", level, 101);

        // Reset mid-burst, then a clean burst afterwards.
        write_n(155);
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        run("pre-reset", 0, 40, 0, 100, cyc);
        RESET_N = 1'b0;
        #1;
        check_idle_outputs("mid-burst reset");
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        tick();
        lvl_exp   = 0;
        rd_exp    = wr_val;
        burst_pos = 0;
        write_n(256);
        transfer_en = 1'b1;
        tick();
        transfer_en = 1'b0;
        check("post-reset active", transfer_active, 1);
        run("post-reset burst", 0, 256, 0, 400, cyc);
        check("post-reset cycles", cyc, 256);

        // Continuous stream of 600 words: two full bursts.
        transfer_en = 1'b1;
        run("stream600", 600, 512, 0, 1200, cyc);
        transfer_en = 1'b0;
        check("stream600 end active", transfer_active, 0);
        check("stream600 residual level", level, 88);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
